// File: rtl/cache_set_assoc.sv
`timescale 1ns/1ps
// cache_set_assoc: N-way set-associative read cache with block refill over a beat
// interface, round-robin replacement and whole-cache flush. Optional counters: CACHE_STATS_EN.
module cache_set_assoc #(
  parameter int ADDR_W      = 64,
  parameter int WAYS        = 4,
  parameter int SETS        = 64,
  parameter int BLOCK_BYTES = 64,
  parameter int BEAT_W      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic [63:0]       resp_data,
  output logic              resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_beat_valid,
  input  logic [BEAT_W-1:0] mem_beat_data,
  input  logic              flush
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);
  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int IDX_B  = $clog2(SETS);
  localparam int IDX_W  = (IDX_B > 0) ? IDX_B : 1;
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_B;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = BLOCK_BYTES * 8;
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORDS  = BLOCK_BYTES / 8;
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESP} state_t;

  // Handshakes: req and mem_req transfer on a rising edge with valid and ready both high,
  // and the valid side holds its payload stable until then; resp and beats have no ready.
  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [WAY_W-1:0]  victim_q;
  logic              victim_was_valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              flush_pend_q;
  logic              alive_q;
  logic              resp_valid_q;
  logic              resp_hit_q;
  logic [63:0]       resp_data_q;
  logic              mem_req_valid_q;
  logic [ADDR_W-1:0] mem_req_addr_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WORD_W-1:0] woff;
  logic [WAYS-1:0]   hit_vec;
  logic              hit_any;
  logic              all_valid;
  logic              last_beat;
  logic              req_fire;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  victim;
  logic [WAY_W-1:0]  rr_next;
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] fill_line;
  logic [63:0]       hit_word;
  logic [63:0]       fill_word;

  assign idx  = IDX_W'((addr_q >> OFF_W) & ADDR_W'(SETS - 1));
  assign tag  = TAG_W'(addr_q >> (OFF_W + IDX_B));
  assign woff = WORD_W'((addr_q >> 3) & ADDR_W'(WORDS - 1));

  assign req_ready = alive_q && (state_q == S_IDLE) && !flush && !flush_pend_q;
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit_vec[w] = 1'b1;
        hit_way    = WAY_W'(w);
      end
      if (!valid_q[idx][w]) inv_way = WAY_W'(w);
    end
    hit_any   = |hit_vec;
    all_valid = &valid_q[idx];
    victim    = all_valid ? rr_q[idx] : inv_way;
    rr_next   = (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
    hit_line  = data_q[idx][hit_way];
    hit_word  = hit_line[int'(woff) * 64 +: 64];
    // Merge the arriving beat so the final beat can supply the requested word directly.
    fill_line = data_q[idx][victim_q];
    fill_line[int'(cnt_q) * BEAT_W +: BEAT_W] = mem_beat_data;
    fill_word = fill_line[int'(woff) * 64 +: 64];
    last_beat = (cnt_q == CNT_W'(BEATS - 1));
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= S_IDLE;
      addr_q             <= '0;
      valid_q            <= '{default: '0};
      rr_q               <= '{default: '0};
      victim_q           <= '0;
      victim_was_valid_q <= 1'b0;
      cnt_q              <= '0;
      flush_pend_q       <= 1'b0;
      alive_q            <= 1'b0;
      resp_valid_q       <= 1'b0;
      resp_hit_q         <= 1'b0;
      resp_data_q        <= '0;
      mem_req_valid_q    <= 1'b0;
      mem_req_addr_q     <= '0;
`ifdef CACHE_STATS_EN
      hit_cnt_q          <= '0;
      miss_cnt_q         <= '0;
`endif
    end else begin
      alive_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      if (flush && state_q != S_IDLE) flush_pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (flush || flush_pend_q) begin
            valid_q      <= '{default: '0};
            rr_q         <= '{default: '0};
            flush_pend_q <= 1'b0;
          end else if (req_fire) begin
            addr_q  <= req_addr;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit_any) begin
            resp_data_q  <= hit_word;
            resp_hit_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
`ifdef CACHE_STATS_EN
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
`endif
          end else begin
            victim_q           <= victim;
            victim_was_valid_q <= all_valid;
            mem_req_valid_q    <= 1'b1;
            mem_req_addr_q     <= addr_q & ~ADDR_W'(BLOCK_BYTES - 1);
            state_q            <= S_MISS_REQ;
`ifdef CACHE_STATS_EN
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
`endif
          end
        end
        S_MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            cnt_q           <= '0;
            state_q         <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_beat_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              valid_q[idx][victim_q] <= 1'b1;
              if (victim_was_valid_q) rr_q[idx] <= rr_next;
              resp_data_q  <= fill_word;
              resp_hit_q   <= 1'b0;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (state_q == S_REFILL && mem_beat_valid) begin
      data_q[idx][victim_q][int'(cnt_q) * BEAT_W +: BEAT_W] <= mem_beat_data;
      if (last_beat) tag_q[idx][victim_q] <= tag;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_hit      = resp_hit_q;
  assign resp_data     = resp_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;

endmodule

// File: tb/tb_cache_set_assoc.sv
`timescale 1ns/1ps
// tb_cache_set_assoc: randomized and directed bench for cache_set_assoc with a
// set/way-level reference model and a word-addressed memory model.
module tb_cache_set_assoc;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic        resp_valid, resp_hit;
  logic [63:0] resp_data;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_beat_valid;
  logic [63:0] mem_beat_data;
  logic        flush;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic        m_valid [64][4];
  logic [51:0] m_tag   [64][4];
  int          m_rr    [64];
  int          exp_hits, exp_misses;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  cache_set_assoc dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_beat_valid(mem_beat_valid), .mem_beat_data(mem_beat_data),
    .flush(flush)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always @(negedge clk) begin
    if (rst === 1'b1 && !$onehot0(dut.hit_vec)) begin
      errors++;
      $display("FAIL multi_hit: hit_vec %b, required at most one way", dut.hit_vec);
    end
  end

  // Memory contents: block 0x1000 holds 0x11*(k+1) in word k; every other word is unique.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [63:0] blk;
    blk = a >> 6;
    return ((blk ^ 64'h40) << 12) | (64'h11 * (64'(a[5:3]) + 64'd1));
  endfunction

  task automatic model_flush();
    for (int s = 0; s < 64; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic model_reset();
    model_flush();
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic model_access(input logic [63:0] a, output logic hit);
    int s, v;
    logic [51:0] t;
    s = int'(a[11:6]);
    t = a[63:12];
    hit = 1'b0;
    for (int w = 0; w < 4; w++) if (m_valid[s][w] && m_tag[s][w] == t) hit = 1'b1;
    if (!hit) begin
      v = -1;
      for (int w = 3; w >= 0; w--) if (!m_valid[s][w]) v = w;
      if (v < 0) begin
        v = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % 4;
      end
      m_valid[s][v] = 1'b1;
      m_tag[s][v] = t;
      exp_misses++;
    end else begin
      exp_hits++;
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_flush();
  endtask

  task automatic do_req(input logic [63:0] a, input int rdy_dly, input int max_gap, input bit flush_mid,
                        output bit got, output logic hit, output logic [63:0] data, output int lat,
                        output bit saw_mem, output logic [63:0] maddr, output int mlat, output bit stable);
    int t;
    got = 1'b0; hit = 1'bx; data = 'x; lat = -1;
    saw_mem = 1'b0; maddr = '0; mlat = -1; stable = 1'b1;
    t = 0;
    while (req_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    for (t = 0; t < 300 && !got; t++) begin
      if (resp_valid === 1'b1) begin
        got = 1'b1; hit = resp_hit; data = resp_data; lat = t;
      end else if (mem_req_valid === 1'b1 && !saw_mem) begin
        saw_mem = 1'b1; maddr = mem_req_addr; mlat = t;
        for (int d = 0; d < rdy_dly; d++) begin
          if (flush_mid && d == 0) flush = 1'b1;
          @(posedge clk); #1;
          flush = 1'b0;
          if (mem_req_valid !== 1'b1 || mem_req_addr !== maddr) stable = 1'b0;
        end
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
          mem_beat_valid = 1'b1;
          mem_beat_data  = mem_word(maddr + 64'(8 * k));
          @(posedge clk); #1;
          mem_beat_valid = 1'b0;
          mem_beat_data  = {$urandom, $urandom};
        end
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_hit !== 1'b0) begin errors++; $display("FAIL reset_resp: valid %b hit %b want 0 0", resp_valid, resp_hit); end
    checks++; if (resp_data !== 64'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 64'h0) begin errors++; $display("FAIL reset_mem_req: valid %b addr %h want 0 0", mem_req_valid, mem_req_addr); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL release_ready_early: got %b want 0", req_ready); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_cold_miss();
    bit got, saw, stable; logic hit, mh; logic [63:0] data, maddr; int lat, mlat;
    model_access(64'h1008, mh);
    do_req(64'h1008, 0, 0, 1'b0, got, hit, data, lat, saw, maddr, mlat, stable);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL cold_resp: got %b want 1", got); end
    checks++; if (saw !== 1'b1 || maddr !== 64'h1000) begin errors++; $display("FAIL cold_mem_addr: req %b addr %h want 1 1000", saw, maddr); end
    checks++; if (mlat !== 1) begin errors++; $display("FAIL cold_mem_latency: got %0d want 1", mlat); end
    checks++; if (hit !== 1'b0 || data !== 64'h22) begin errors++; $display("FAIL cold_data: hit %b data %h want 0 22", hit, data); end
  endtask

  task automatic test_rehit();
    bit got, saw, stable; logic hit, mh; logic [63:0] data, maddr; int lat, mlat;
    model_access(64'h1038, mh);
    do_req(64'h1038, 0, 0, 1'b0, got, hit, data, lat, saw, maddr, mlat, stable);
    checks++; if (got !== 1'b1 || lat !== 1) begin errors++; $display("FAIL rehit_latency: resp %b lat %0d want 1 1", got, lat); end
    checks++; if (hit !== 1'b1 || data !== 64'h88) begin errors++; $display("FAIL rehit_data: hit %b data %h want 1 88", hit, data); end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rehit_no_mem: mem_req %b want 0", saw); end
  endtask

  task automatic test_replacement();
    logic [63:0] seq [7];
    bit          want_hit [7];
    bit got, saw, stable; logic hit, mh; logic [63:0] data, maddr; int lat, mlat;
    seq = '{64'h0000, 64'h1000, 64'h2000, 64'h3000, 64'h4000, 64'h1000, 64'h0000};
    want_hit = '{0, 0, 0, 0, 0, 1, 0};
    pulse_flush();
    for (int i = 0; i < 7; i++) begin
      model_access(seq[i], mh);
      do_req(seq[i], $urandom_range(0, 2), 1, 1'b0, got, hit, data, lat, saw, maddr, mlat, stable);
      checks++;
      if (got !== 1'b1 || hit !== want_hit[i] || data !== mem_word(seq[i])) begin
        errors++;
        $display("FAIL replace_%0d addr %h: resp %b hit %b data %h want 1 %b %h", i, seq[i], got, hit, data, want_hit[i], mem_word(seq[i]));
      end
    end
  endtask

  task automatic test_flush_collision();
    bit got, saw, stable; logic hit, mh; logic [63:0] data, maddr; int lat, mlat, t;
    t = 0;
    while (req_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    flush = 1'b1; req_valid = 1'b1; req_addr = 64'h1000;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL collide_ready: got %b want 0", req_ready); end
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    model_flush();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL collide_not_accepted: resp %b mem_req %b want 0 0", resp_valid, mem_req_valid); end
    model_access(64'h1000, mh);
    do_req(64'h1000, 0, 0, 1'b0, got, hit, data, lat, saw, maddr, mlat, stable);
    checks++; if (got !== 1'b1 || hit !== mh || saw !== 1'b1) begin errors++; $display("FAIL collide_then_miss: resp %b hit %b mem %b want 1 %b 1", got, hit, saw, mh); end
  endtask

  task automatic test_reset_mid_refill();
    bit got, saw, stable; logic hit, mh; logic [63:0] data, maddr; int lat, mlat, t;
    pulse_flush();
    t = 0;
    while (req_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    req_valid = 1'b1; req_addr = 64'h1000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    t = 0;
    while (mem_req_valid !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL midrst_mem_req: got %b want 1", mem_req_valid); end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_beat_valid = 1'b1; mem_beat_data = mem_word(64'h1000 + 64'(8 * k));
      @(posedge clk); #1;
      mem_beat_valid = 1'b0;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_data !== 64'h0 ||
        mem_req_valid !== 1'b0 || mem_req_addr !== 64'h0) begin
      errors++;
      $display("FAIL midrst_outputs: ready %b rv %b rh %b rd %h mrv %b mra %h want all 0",
               req_ready, resp_valid, resp_hit, resp_data, mem_req_valid, mem_req_addr);
    end
`ifdef CACHE_STATS_EN
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("FAIL midrst_stats: hit %0d miss %0d want 0 0", hit_cnt, miss_cnt); end
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b want 1", req_ready); end
    model_access(64'h1000, mh);
    do_req(64'h1000, 1, 1, 1'b0, got, hit, data, lat, saw, maddr, mlat, stable);
    checks++;
    if (got !== 1'b1 || hit !== 1'b0 || saw !== 1'b1 || data !== 64'h11) begin
      errors++;
      $display("FAIL midrst_refill: resp %b hit %b mem %b data %h want 1 0 1 11", got, hit, saw, data);
    end
  endtask

  task automatic test_stall_and_pending_flush();
    bit got, saw, stable; logic hit, mh; logic [63:0] data, maddr; int lat, mlat;
    model_access(64'h5008, mh);
    do_req(64'h5008, 5, 1, 1'b0, got, hit, data, lat, saw, maddr, mlat, stable);
    checks++; if (stable !== 1'b1 || saw !== 1'b1 || maddr !== 64'h5000) begin errors++; $display("FAIL stall_stable: stable %b mem %b addr %h want 1 1 5000", stable, saw, maddr); end
    checks++; if (got !== 1'b1 || hit !== 1'b0 || data !== mem_word(64'h5008)) begin errors++; $display("FAIL stall_data: resp %b hit %b data %h want 1 0 %h", got, hit, data, mem_word(64'h5008)); end
    model_access(64'h6010, mh);
    do_req(64'h6010, 3, 1, 1'b1, got, hit, data, lat, saw, maddr, mlat, stable);
    model_flush();
    checks++; if (got !== 1'b1 || hit !== 1'b0 || data !== mem_word(64'h6010)) begin errors++; $display("FAIL pend_flush_resp: resp %b hit %b data %h want 1 0 %h", got, hit, data, mem_word(64'h6010)); end
    model_access(64'h6010, mh);
    do_req(64'h6010, 0, 0, 1'b0, got, hit, data, lat, saw, maddr, mlat, stable);
    checks++; if (got !== 1'b1 || hit !== mh || saw !== 1'b1) begin errors++; $display("FAIL pend_flush_applied: resp %b hit %b mem %b want 1 %b 1", got, hit, saw, mh); end
  endtask

  task automatic test_random();
    bit got, saw, stable; logic hit, mh; logic [63:0] a, data, maddr, exp_d; int lat, mlat;
    for (int i = 0; i < 60; i++) begin
      a = (64'($urandom_range(0, 7)) << 12) | (64'($urandom_range(0, 3)) << 6) |
          (64'($urandom_range(0, 7)) << 3) | 64'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        mem_beat_valid = 1'b1; mem_beat_data = {$urandom, $urandom};
        @(posedge clk); #1;
        mem_beat_valid = 1'b0;
      end
      model_access(a, mh);
      exp_q.push_back(mem_word(a));
      do_req(a, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, got, hit, data, lat, saw, maddr, mlat, stable);
      exp_d = exp_q.pop_front();
      checks++;
      if (got !== 1'b1 || hit !== mh || data !== exp_d) begin
        errors++;
        $display("FAIL rand_%0d addr %h: resp %b hit %b data %h want 1 %b %h", i, a, got, hit, data, mh, exp_d);
      end
      checks++;
      if (mh ? (saw !== 1'b0 || lat !== 1) : (saw !== 1'b1 || maddr !== (a & ~64'h3f) || stable !== 1'b1)) begin
        errors++;
        $display("FAIL rand_%0d_path addr %h: mem %b maddr %h lat %0d stable %b want hit %b", i, a, saw, maddr, lat, stable, mh);
      end
    end
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_stats();
    checks++;
    if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
      errors++;
      $display("FAIL stats: hit %0d miss %0d want %0d %0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; mem_req_ready = 1'b0;
    mem_beat_valid = 1'b0; mem_beat_data = '0; flush = 1'b0;
    model_reset();
    test_reset();
    test_cold_miss();
    test_rehit();
    test_replacement();
    test_flush_collision();
    test_reset_mid_refill();
    test_stall_and_pending_flush();
    test_random();
`ifdef CACHE_STATS_EN
    test_stats();
`endif
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
